// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous font ROM between the banner
// renderer (client 0) and the guess/score renderer (client 1).
module font_rom_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_C0,
        OWN_C1
    } owner_t;

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

    owner_t           owner, owner_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last_gnt, last_gnt_nxt;  // 0: client 0 last, 1: client 1 last
    logic             burst_open;

    assign burst_open = (cnt < BURST_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= OWN_NONE;
            cnt      <= '0;
            last_gnt <= 1'b1;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            owner    <= owner_nxt;
            cnt      <= cnt_nxt;
            last_gnt <= last_gnt_nxt;
            rvalid0  <= gnt0;
            rvalid1  <= gnt1;
        end
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (owner == OWN_C0 && req0 && (burst_open || !req1)) begin
            gnt0 = 1'b1;
        end else if (owner == OWN_C1 && req1 && (burst_open || !req0)) begin
            gnt1 = 1'b1;
        end else if (req0 && req1) begin
            // Tie goes to whichever client was not granted most recently.
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
        end else if (req0) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end
    end

    always_comb begin
        owner_nxt    = OWN_NONE;
        cnt_nxt      = '0;
        last_gnt_nxt = last_gnt;
        if (gnt0) begin
            last_gnt_nxt = 1'b0;
            owner_nxt    = OWN_C0;
            if (owner == OWN_C0) begin
                cnt_nxt = burst_open ? cnt + 1'b1 : cnt;
            end else begin
                cnt_nxt = CNT_W'(1);
            end
        end else if (gnt1) begin
            last_gnt_nxt = 1'b1;
            owner_nxt    = OWN_C1;
            if (owner == OWN_C1) begin
                cnt_nxt = burst_open ? cnt + 1'b1 : cnt;
            end else begin
                cnt_nxt = CNT_W'(1);
            end
        end
    end

    always_comb begin
        rom_addr = '0;
        if (gnt0) begin
            rom_addr = addr0;
        end else if (gnt1) begin
            rom_addr = addr1;
        end
    end

    assign rdata = rom_data;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed self-checking bench for font_rom_arbiter with a behavioural
// 1-cycle-latency font ROM.
module tb_font_rom_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic              gnt0, gnt1;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    font_rom_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_BURST(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req0(req0),
        .addr0(addr0),
        .req1(req1),
        .addr1(addr1),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .rvalid0(rvalid0),
        .rvalid1(rvalid1),
        .rdata(rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ {a[10:8], 5'b10110};
    endfunction

    always_ff @(posedge clk) rom_data <= rom_word(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then let outputs settle.
    task automatic cyc(input logic rst, input logic r0, input logic [ADDR_W-1:0] a0,
                       input logic r1, input logic [ADDR_W-1:0] a1);
        @(negedge clk);
        reset = rst;
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
        #1;
    endtask

    initial begin
        logic pg0, pg1;
        logic [ADDR_W-1:0] pa;
        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 11'h100;
        addr1 = 11'h200;

        // Reset held with both requesting
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 11'h100, 1'b1, 11'h200);
            check("rst_gnt0", gnt0, 0);
            check("rst_gnt1", gnt1, 0);
            check("rst_addr", rom_addr, 0);
            check("rst_rv0", rvalid0, 0);
            check("rst_rv1", rvalid1, 0);
        end
        cyc(1'b0, 1'b1, 11'h100, 1'b1, 11'h200);
        check("rel_gnt0", gnt0, 1);
        check("rel_gnt1", gnt1, 0);
        check("rel_addr", rom_addr, 11'h100);
        cyc(1'b0, 1'b0, 11'h000, 1'b0, 11'h000);
        check("rel_rv0", rvalid0, 1);
        check("rel_rdata", rdata, rom_word(11'h100));

        // Single read of 'B' row 1
        cyc(1'b0, 1'b1, 11'h421, 1'b0, 11'h000);
        check("b1_gnt0", gnt0, 1);
        check("b1_gnt1", gnt1, 0);
        check("b1_addr", rom_addr, 11'h421);
        cyc(1'b0, 1'b0, 11'h000, 1'b0, 11'h000);
        check("b1_rv0", rvalid0, 1);
        check("b1_rv1", rvalid1, 0);
        check("b1_rdata", rdata, rom_word(11'h421));
        check("b1_gnt1_after", gnt1, 0);

        // Contended streaming from a fresh reset: bursts of 4
        cyc(1'b1, 1'b0, 11'h000, 1'b0, 11'h000);
        pg0 = 1'b0;
        pg1 = 1'b0;
        pa  = '0;
        for (int i = 0; i < 16; i++) begin
            logic e1;
            e1 = ((i / 4) % 2) == 1;
            cyc(1'b0, 1'b1, 11'h0A5, 1'b1, 11'h3C7);
            check($sformatf("rr_gnt0[%0d]", i), gnt0, !e1);
            check($sformatf("rr_gnt1[%0d]", i), gnt1, e1);
            check($sformatf("rr_addr[%0d]", i), rom_addr, e1 ? 11'h3C7 : 11'h0A5);
            check($sformatf("rr_rv0[%0d]", i), rvalid0, pg0);
            check($sformatf("rr_rv1[%0d]", i), rvalid1, pg1);
            if (pg0 || pg1) check($sformatf("rr_rdata[%0d]", i), rdata, rom_word(pa));
            pg0 = !e1;
            pg1 = e1;
            pa  = e1 ? 11'h3C7 : 11'h0A5;
        end

        // Idle after a client-1 grant, then both reassert
        cyc(1'b0, 1'b0, 11'h000, 1'b0, 11'h000);
        check("idle_gnt0", gnt0, 0);
        check("idle_gnt1", gnt1, 0);
        check("idle_addr", rom_addr, 0);
        check("idle_rv1", rvalid1, 1);
        cyc(1'b0, 1'b1, 11'h0A5, 1'b1, 11'h3C7);
        check("reass_gnt0", gnt0, 1);
        check("reass_gnt1", gnt1, 0);

        // Owner drops while the other arrives: handoff with no idle cycle
        cyc(1'b0, 1'b0, 11'h000, 1'b1, 11'h3C7);
        check("hand_gnt1", gnt1, 1);
        check("hand_addr", rom_addr, 11'h3C7);

        // Uncontested client 0 for 10 cycles, then client 1 arrives
        cyc(1'b0, 1'b0, 11'h000, 1'b0, 11'h000);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 11'h2B3, 1'b0, 11'h000);
            check($sformatf("solo_gnt0[%0d]", i), gnt0, 1);
        end
        cyc(1'b0, 1'b1, 11'h2B3, 1'b1, 11'h611);
        check("solo_end_gnt1", gnt1, 1);
        check("solo_end_gnt0", gnt0, 0);
        check("solo_end_addr", rom_addr, 11'h611);

        // Reset while client 1 owns the ROM with cnt=2
        cyc(1'b0, 1'b0, 11'h000, 1'b0, 11'h000);
        cyc(1'b0, 1'b0, 11'h000, 1'b1, 11'h611);
        cyc(1'b0, 1'b0, 11'h000, 1'b1, 11'h612);
        check("mid_gnt1_pre", gnt1, 1);
        cyc(1'b1, 1'b1, 11'h055, 1'b1, 11'h613);
        check("mid_rst_gnt1", gnt1, 0);
        check("mid_rst_gnt0", gnt0, 0);
        check("mid_rst_addr", rom_addr, 0);
        cyc(1'b0, 1'b1, 11'h055, 1'b1, 11'h613);
        check("mid_post_rv1", rvalid1, 0);
        check("mid_post_rv0", rvalid0, 0);
        check("mid_post_gnt0", gnt0, 1);
        check("mid_post_gnt1", gnt1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
